mem_stage_mc: RTL and testbench

MEM_STAGE_MC -- requirements
Module: mem_stage_mc

---
 rtl/mem_stage_pkg.sv | 16 +
 rtl/mem_stage_lane_align.sv | 58 +++++
 rtl/mem_stage_mc.sv | 178 +++++++++++++++++
 tb/tb_mem_stage_mc.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the multi-cycle memory stage.
//   state_e : access FSM states (idle, wait states, single-cycle done)
//   SZ_*    : mem_size encodings; 2'b11 is handled as a word access
package mem_stage_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StDone = 2'b10
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_stage_lane_align.sv
// Combinational lane steering for the memory stage.
//   size, load_unsigned, byte_off : access shape
//   st_val  : store data (sub-word data in the low bits)
//   rd_word : current contents of the addressed memory word
//   wr_data : store data shifted into its byte lanes
//   wr_mask : bit mask of lanes the store may modify
//   ld_val  : extracted and extended load result
// Sub-word support only exists when MEM_SUBWORD_EN is defined (DATA_W must then be 32);
// otherwise every access is a full word and the shape inputs are ignored.
module mem_stage_lane_align
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic              load_unsigned,
  input  logic [1:0]        byte_off,
  input  logic [DATA_W-1:0] st_val,
  input  logic [DATA_W-1:0] rd_word,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] wr_mask,
  output logic [DATA_W-1:0] ld_val
);

`ifdef MEM_SUBWORD_EN
  logic [4:0]  shift;
  logic [15:0] lane;

  always_comb begin
    shift   = {byte_off, 3'b000};
    lane    = 16'(rd_word >> shift);
    wr_data = st_val << shift;
    wr_mask = '1;
    ld_val  = rd_word;
    unique case (size)
      SZ_BYTE: begin
        wr_mask = DATA_W'(32'h0000_00ff) << shift;
        ld_val  = load_unsigned ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      end
      SZ_HALF: begin
        wr_mask = DATA_W'(32'h0000_ffff) << shift;
        ld_val  = load_unsigned ? {16'h0, lane} : {{16{lane[15]}}, lane};
      end
      default: begin
        wr_data = st_val;
      end
    endcase
  end
`else
  logic unused_shape;
  assign unused_shape = ^{size, load_unsigned, byte_off};

  assign wr_data = st_val;
  assign wr_mask = '1;
  assign ld_val  = rd_word;
`endif

endmodule

// File: rtl/mem_stage_mc.sv
// Multi-cycle data-memory pipeline stage.
//   clk, rst        : clock, asynchronous active-low reset
//   mem_r_en/w_en   : load/store request (both high = store)
//   mem_size        : byte/half/word, load_unsigned selects zero-extension
//   alu_result_in   : byte address; st_val : store data
//   mem_read_value  : registered load result, updated only on load completion
//   freeze          : stall for upstream registers while an access is pending
//   done / addr_err : one-cycle completion pulse / fault flag during that pulse
// Optional feature macro: MEM_SUBWORD_EN (byte/half accesses, per-size alignment).
module mem_stage_mc
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned BASE_ADDR = 1024,
  parameter int unsigned WAIT_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [1:0]        mem_size,
  input  logic              load_unsigned,
  input  logic [ADDR_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] st_val,
  output logic [DATA_W-1:0] mem_read_value,
  output logic              freeze,
  output logic              done,
  output logic              addr_err
);

  localparam int unsigned      IdxW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] Base   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] Limit  = ADDR_W'(BASE_ADDR + 4 * DEPTH);
  localparam logic [3:0]       CntInit = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rv_q, rv_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic [DATA_W-1:0]   data_q;
  logic                store_q, load_q, uns_q;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                req, in_idle, go, fault, misaligned, mem_we;
  logic [ADDR_W-1:0]   cur_addr, offset;
  logic [1:0]          cur_size;
  logic [DATA_W-1:0]   cur_data, rd_word, wr_data, wr_mask, ld_val;
  logic                cur_store, cur_load, cur_uns;
  logic [IdxW-1:0]     idx;

  assign req     = mem_r_en | mem_w_en;
  assign in_idle = (state_q == StIdle);

  // With WAIT_CYC=0 the access completes on the capture edge, so the live inputs
  // feed the datapath in IDLE and the captured copies are used otherwise.
  assign cur_addr  = in_idle ? alu_result_in : addr_q;
  assign cur_size  = in_idle ? mem_size : size_q;
  assign cur_data  = in_idle ? st_val : data_q;
  assign cur_store = in_idle ? mem_w_en : store_q;
  assign cur_load  = in_idle ? (mem_r_en & ~mem_w_en) : load_q;
  assign cur_uns   = in_idle ? load_unsigned : uns_q;

  assign offset  = cur_addr - Base;
  assign idx     = IdxW'(offset >> 2);
  assign rd_word = mem_q[idx];

`ifdef MEM_SUBWORD_EN
  always_comb begin
    unique case (cur_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = cur_addr[0];
      default: misaligned = |cur_addr[1:0];
    endcase
  end
`else
  assign misaligned = |cur_addr[1:0];
`endif

  assign fault = (cur_addr < Base) | (cur_addr >= Limit) | misaligned;

  mem_stage_lane_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .size         (cur_size),
    .load_unsigned(cur_uns),
    .byte_off     (cur_addr[1:0]),
    .st_val       (cur_data),
    .rd_word      (rd_word),
    .wr_data      (wr_data),
    .wr_mask      (wr_mask),
    .ld_val       (ld_val)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rv_d    = rv_q;
    err_d   = err_q;
    go      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          if (WAIT_CYC == 0) begin
            state_d = StDone;
            go      = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          go      = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
    if (go) begin
      err_d = fault;
      if (cur_load) rv_d = fault ? '0 : ld_val;
    end
  end

  // Gated by rst so a request held during reset can never commit a store.
  assign mem_we = go & cur_store & ~fault & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rv_q    <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= SZ_WORD;
      data_q  <= '0;
      store_q <= 1'b0;
      load_q  <= 1'b0;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      if (in_idle && req) begin
        addr_q  <= alu_result_in;
        size_q  <= mem_size;
        data_q  <= st_val;
        store_q <= mem_w_en;
        load_q  <= mem_r_en & ~mem_w_en;
        uns_q   <= load_unsigned;
      end
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= (rd_word & ~wr_mask) | (wr_data & wr_mask);
  end

  assign freeze         = (in_idle & req) | (state_q == StWait);
  assign done           = (state_q == StDone);
  assign addr_err       = done & err_q;
  assign mem_read_value = rv_q;

endmodule

// File: tb/tb_mem_stage_mc.sv
module tb_mem_stage_mc;

  typedef struct {
    logic [31:0] rv;
    logic        err;
    int          frz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r_en [3];
  logic        w_en [3];
  logic        uns  [3];
  logic [1:0]  sz   [3];
  logic [31:0] addr [3];
  logic [31:0] sval [3];
  logic [31:0] rv   [3];
  logic        fr   [3];
  logic        dn   [3];
  logic        er   [3];

  logic [31:0] model_rv [3];
  int          wc [3];
  exp_t        sb_q [$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

  mem_stage_mc #(.WAIT_CYC(1)) u_dut0 (
    .clk(clk), .rst(rst), .mem_r_en(r_en[0]), .mem_w_en(w_en[0]), .mem_size(sz[0]),
    .load_unsigned(uns[0]), .alu_result_in(addr[0]), .st_val(sval[0]),
    .mem_read_value(rv[0]), .freeze(fr[0]), .done(dn[0]), .addr_err(er[0])
  );

  mem_stage_mc #(.WAIT_CYC(3)) u_dut1 (
    .clk(clk), .rst(rst), .mem_r_en(r_en[1]), .mem_w_en(w_en[1]), .mem_size(sz[1]),
    .load_unsigned(uns[1]), .alu_result_in(addr[1]), .st_val(sval[1]),
    .mem_read_value(rv[1]), .freeze(fr[1]), .done(dn[1]), .addr_err(er[1])
  );

  mem_stage_mc #(.WAIT_CYC(0)) u_dut2 (
    .clk(clk), .rst(rst), .mem_r_en(r_en[2]), .mem_w_en(w_en[2]), .mem_size(sz[2]),
    .load_unsigned(uns[2]), .alu_result_in(addr[2]), .st_val(sval[2]),
    .mem_read_value(rv[2]), .freeze(fr[2]), .done(dn[2]), .addr_err(er[2])
  );

  task automatic idle_inputs(input int i);
    r_en[i] = 1'b0;
    w_en[i] = 1'b0;
    uns[i]  = 1'b0;
    sz[i]   = 2'b10;
    addr[i] = 32'd0;
    sval[i] = 32'd0;
  endtask

  // Drives one access starting at the current time (caller is just after a negedge),
  // pushes the expectation, waits for done, pops and compares, and returns one cycle
  // later with the DUT back in IDLE.
  task automatic access(input int i, input logic rd, input logic wr, input logic [1:0] s,
                        input logic lu, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data, input logic exp_err, input string name);
    exp_t e;
    int   frz_cnt = 0;
    bit   seen = 1'b0;
    if (rd && !wr) e.rv = exp_err ? 32'd0 : exp_data;
    else e.rv = model_rv[i];
    model_rv[i] = e.rv;
    e.err = exp_err;
    e.frz = wc[i] + 1;
    sb_q.push_back(e);
    r_en[i] = rd; w_en[i] = wr; sz[i] = s; uns[i] = lu; addr[i] = a; sval[i] = d;
    #1;
    for (int c = 0; c < 40; c++) begin
      if (fr[i]) frz_cnt++;
      if (dn[i]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    e = sb_q.pop_front();
    total_cnt++;
    if (!seen) begin
      $display("FAIL %s timeout: done not seen within 40 cycles", name);
      idle_inputs(i);
      @(negedge clk); #1;
      return;
    end
    pass_cnt++;
    total_cnt++;
    if (rv[i] !== e.rv) $display("FAIL %s read_value: got %h expected %h", name, rv[i], e.rv);
    else pass_cnt++;
    total_cnt++;
    if (er[i] !== e.err) $display("FAIL %s addr_err: got %b expected %b", name, er[i], e.err);
    else pass_cnt++;
    total_cnt++;
    if (frz_cnt != e.frz) $display("FAIL %s freeze_cycles: got %0d expected %0d", name, frz_cnt, e.frz);
    else pass_cnt++;
    idle_inputs(i);
    @(negedge clk); #1;
    total_cnt++;
    if (dn[i] !== 1'b0 || er[i] !== 1'b0)
      $display("FAIL %s done_pulse: got done=%b err=%b expected 0/0", name, dn[i], er[i]);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (rv[i] !== 32'd0 || dn[i] !== 1'b0 || er[i] !== 1'b0 || fr[i] !== 1'b0)
        $display("FAIL reset_state[%0d]: got rv=%h done=%b err=%b freeze=%b expected 0", i,
                 rv[i], dn[i], er[i], fr[i]);
      else pass_cnt++;
    end
    r_en[0] = 1'b1;
    #1;
    total_cnt++;
    if (fr[0] !== 1'b1) $display("FAIL freeze_comb: got %b expected 1", fr[0]);
    else pass_cnt++;
    r_en[0] = 1'b0;
    #1;
    total_cnt++;
    if (fr[0] !== 1'b0) $display("FAIL freeze_idle: got %b expected 0", fr[0]);
    else pass_cnt++;
    @(negedge clk); #1;
  endtask

  task automatic test_word();
    access(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h0, 1'b0, "sw_1024");
    access(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 1'b0, "lw_1024");
  endtask

  task automatic test_addr_err();
    access(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'd1022, 32'h0, 32'h0, 1'b1, "lw_below_base");
    access(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'd1280, 32'h0, 32'h0, 1'b1, "lw_past_end");
    access(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'd1280, 32'h55, 32'h0, 1'b1, "sw_past_end");
    access(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 1'b0, "lw_after_fault");
    access(0, 1'b1, 1'b0, 2'b01, 1'b0, 32'd1027, 32'h0, 32'h0, 1'b1, "lh_misaligned");
  endtask

  task automatic test_both_enables();
    access(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'd1028, 32'h12345678, 32'h0, 1'b0, "both_en_store");
    access(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'd1028, 32'h0, 32'h12345678, 1'b0, "lw_1028");
  endtask

  task automatic test_subword();
`ifdef MEM_SUBWORD_EN
    access(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'd1024, 32'h0, 32'h0, 1'b0, "sw_zero");
    access(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'd1025, 32'h80, 32'h0, 1'b0, "sb_1025");
    access(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'd1025, 32'h0, 32'hFFFFFF80, 1'b0, "lb_1025");
    access(0, 1'b1, 1'b0, 2'b00, 1'b1, 32'd1025, 32'h0, 32'h00000080, 1'b0, "lbu_1025");
    access(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'd1024, 32'h0, 32'h00008000, 1'b0, "lw_after_sb");
    access(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'd1030, 32'h0000BEEF, 32'h0, 1'b0, "sh_1030");
    access(0, 1'b1, 1'b0, 2'b01, 1'b0, 32'd1030, 32'h0, 32'hFFFFBEEF, 1'b0, "lh_1030");
    access(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'd1028, 32'h0, 32'hBEEF5678, 1'b0, "lw_after_sh");
`else
    access(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'd1040, 32'h12345678, 32'h0, 1'b0, "sb_as_word");
    access(0, 1'b1, 1'b0, 2'b00, 1'b1, 32'd1040, 32'h0, 32'h12345678, 1'b0, "lbu_as_word");
`endif
  endtask

  task automatic test_back_to_back();
    access(2, 1'b0, 1'b1, 2'b10, 1'b0, 32'd1036, 32'hA5A5A5A5, 32'h0, 1'b0, "b2b_sw_a");
    access(2, 1'b0, 1'b1, 2'b10, 1'b0, 32'd1040, 32'h5A5A0001, 32'h0, 1'b0, "b2b_sw_b");
    access(2, 1'b1, 1'b0, 2'b10, 1'b0, 32'd1036, 32'h0, 32'hA5A5A5A5, 1'b0, "b2b_lw_a");
    access(2, 1'b1, 1'b0, 2'b10, 1'b0, 32'd1040, 32'h0, 32'h5A5A0001, 1'b0, "b2b_lw_b");
  endtask

  task automatic test_reset_abort();
    access(1, 1'b0, 1'b1, 2'b10, 1'b0, 32'd1032, 32'h11111111, 32'h0, 1'b0, "abort_pre_sw");
    w_en[1] = 1'b1; addr[1] = 32'd1032; sval[1] = 32'hAAAA5555;
    @(negedge clk); #1;
    @(negedge clk); #1;
    total_cnt++;
    if (fr[1] !== 1'b1) $display("FAIL abort_in_wait: got freeze=%b expected 1", fr[1]);
    else pass_cnt++;
    idle_inputs(1);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (fr[1] !== 1'b0 || dn[1] !== 1'b0 || er[1] !== 1'b0)
      $display("FAIL abort_reset_outputs: got freeze=%b done=%b err=%b expected 0/0/0",
               fr[1], dn[1], er[1]);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) model_rv[i] = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    access(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'd1032, 32'h0, 32'h11111111, 1'b0, "abort_post_lw");
  endtask

  initial begin
    wc[0] = 1; wc[1] = 3; wc[2] = 0;
    for (int i = 0; i < 3; i++) begin
      idle_inputs(i);
      model_rv[i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    test_reset();
    test_word();
    test_addr_err();
    test_both_enables();
    test_subword();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
